// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue controller and its helpers.
package div_pkg;
  localparam int OPW  = 32;
  localparam int LENW = 5;

  localparam int ERR_DIV0    = 0;
  localparam int ERR_RANGE   = 1;
  localparam int ERR_TIMEOUT = 2;

  typedef enum logic [2:0] {
    IDLE, SCAN, ISSUE, DIV_LOW, DIV_HIGH, RESP
  } state_t;
endpackage

// File: rtl/lead_one_scan.sv
// Serial bit-length finder: one bit per cycle from bit 30 down to bit 0.
module lead_one_scan
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [OPW-1:0]  value,
  output logic            busy,
  output logic [LENW-1:0] len
);
  logic [OPW-1:0]  val_r;
  logic [LENW-1:0] idx_r;
  logic [LENW-1:0] len_r;
  logic            hit;

  // len already folds in the bit under test, so the owner can read the
  // final length during the idx==0 cycle.
  assign hit  = busy && (len_r == '0) && val_r[idx_r];
  assign len  = hit ? idx_r + LENW'(1) : len_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_r <= '0;
      idx_r <= '0;
      len_r <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      val_r <= value;
      idx_r <= LENW'(OPW - 2);
      len_r <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      len_r <= len;
      if (idx_r == '0) busy  <= 1'b0;
      else             idx_r <= idx_r - LENW'(1);
    end
  end
endmodule

// File: rtl/divide_issue_ctrl.sv
// Front-end sequencer for the divider core: screens operands, measures their
// bit lengths, issues the core and returns the result over a valid/ready port.
module divide_issue_ctrl
  import div_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_dividend,
  input  logic [OPW-1:0]  in_divisor,
  output logic            div_start,
  output logic [OPW-1:0]  div_dividend,
  output logic [OPW-1:0]  div_divisor,
  output logic [LENW-1:0] div_m,
  output logic [LENW-1:0] div_n,
  input  logic            div_done,
  input  logic [OPW-1:0]  div_q,
  input  logic [OPW-1:0]  div_rem,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_q,
  output logic [OPW-1:0]  out_rem,
  output logic [2:0]      out_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_TO   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SCAN_TOP = CW'(OPW - 2);

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [LENW-1:0] m_len, n_len;
  logic            m_busy, n_busy;
  logic            ld, set_mn, cap, e_div0, e_range, e_triv, e_to;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);
  assign div_start = (state == ISSUE);

  lead_one_scan u_scan_m (.clk(clk), .rst_n(rst_n), .load(ld), .value(in_dividend),
                          .busy(m_busy), .len(m_len));
  lead_one_scan u_scan_n (.clk(clk), .rst_n(rst_n), .load(ld), .value(in_divisor),
                          .busy(n_busy), .len(n_len));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    ld = 1'b0; set_mn = 1'b0; cap = 1'b0;
    e_div0 = 1'b0; e_range = 1'b0; e_triv = 1'b0; e_to = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        ld = 1'b1;
        if (in_divisor == '0) begin
          e_div0 = 1'b1; state_n = RESP;
        end else if (in_dividend[OPW-1] || in_divisor[OPW-1]) begin
          e_range = 1'b1; state_n = RESP;
        end else state_n = SCAN;
      end
      SCAN: if (cnt == '0) begin
        set_mn = 1'b1;
        if ((m_len < n_len) || (div_dividend == '0)) begin
          e_triv = 1'b1; state_n = RESP;
        end else state_n = ISSUE;
      end
      ISSUE: state_n = DIV_LOW;
      // done idles high, so wait for the drop before trusting its rise
      DIV_LOW:
        if (!div_done)          state_n = DIV_HIGH;
        else if (cnt == CNT_TO) begin e_to = 1'b1; state_n = RESP; end
      DIV_HIGH:
        if (div_done)           begin cap = 1'b1; state_n = RESP; end
        else if (cnt == CNT_TO) begin e_to = 1'b1; state_n = RESP; end
      RESP: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      div_dividend <= '0; div_divisor <= '0;
      div_m <= '0; div_n <= '0;
      out_q <= '0; out_rem <= '0; out_err <= '0;
    end else begin
      if (ld) begin
        div_dividend <= in_dividend;
        div_divisor  <= in_divisor;
        cnt          <= SCAN_TOP;
      end else if (state == SCAN && cnt != '0) cnt <= cnt - CW'(1);
      else if (state == ISSUE) cnt <= '0;
      else if (state == DIV_LOW || state == DIV_HIGH) cnt <= cnt + CW'(1);

      if (set_mn) begin
        div_m <= m_len;
        div_n <= n_len;
      end

      if (e_div0) begin
        out_q <= '0; out_rem <= in_dividend; out_err <= 3'b0;
        out_err[ERR_DIV0] <= 1'b1;
      end else if (e_range) begin
        out_q <= '0; out_rem <= '0; out_err <= 3'b0;
        out_err[ERR_RANGE] <= 1'b1;
      end else if (e_triv) begin
        out_q <= '0; out_rem <= div_dividend; out_err <= 3'b0;
      end else if (cap) begin
        out_q <= div_q; out_rem <= div_rem; out_err <= 3'b0;
      end else if (e_to) begin
        out_q <= '0; out_rem <= '0; out_err <= 3'b0;
        out_err[ERR_TIMEOUT] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_divide_issue_ctrl.sv
// Directed bench for divide_issue_ctrl with a behavioural divider core model.
module tb_divide_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_dividend = '0, in_divisor = '0;
  logic        div_start;
  logic [31:0] div_dividend, div_divisor;
  logic [4:0]  div_m, div_n;
  logic        div_done;
  logic [31:0] div_q, div_rem;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_q, out_rem;
  logic [2:0]  out_err;

  int tests = 0, fails = 0;
  int starts = 0, dbl = 0;
  logic start_prev = 1'b0;

  // core model: done idles high, drops on start, rises with q/rem after a delay
  logic        core_done = 1'b1, core_busy = 1'b0, stub = 1'b0;
  int          core_cnt = 0;
  logic [31:0] ca = '0, cb = '1, cq = '0, crem = '0;
  assign div_done = stub ? 1'b1 : core_done;
  assign div_q    = cq;
  assign div_rem  = crem;

  always #5 clk = ~clk;

  divide_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_m(div_m), .div_n(div_n),
    .div_done(div_done), .div_q(div_q), .div_rem(div_rem), .out_valid(out_valid),
    .out_ready(out_ready), .out_q(out_q), .out_rem(out_rem), .out_err(out_err));

  always @(posedge clk) begin
    if (core_busy) begin
      if (core_cnt == 0) begin
        cq <= ca / cb; crem <= ca % cb; core_done <= 1'b1; core_busy <= 1'b0;
      end else core_cnt <= core_cnt - 1;
    end else if (div_start) begin
      core_busy <= 1'b1; core_done <= 1'b0; core_cnt <= 6;
      ca <= div_dividend; cb <= div_divisor;
    end
  end

  always @(posedge clk) begin
    if (div_start) starts <= starts + 1;
    if (div_start && start_prev) dbl <= dbl + 1;
    start_prev <= div_start;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    in_dividend = a; in_divisor = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_resp(input int max);
    int c = 0;
    while (!out_valid && c < max) begin @(negedge clk); c++; end
    chk("resp_within_bound", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_100_7(input string tag);
    int s0 = starts;
    send(32'd100, 32'd7);
    wait_resp(200);
    chk({tag, "_m"}, {27'b0, div_m}, 32'd7);
    chk({tag, "_n"}, {27'b0, div_n}, 32'd3);
    chk({tag, "_starts"}, starts - s0, 32'd1);
    chk({tag, "_q"}, out_q, 32'd14);
    chk({tag, "_rem"}, out_rem, 32'd2);
    chk({tag, "_err"}, {29'b0, out_err}, 32'd0);
    take();
    chk({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int s0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_div_start", {31'b0, div_start}, 32'd0);
    chk("rst_div_m", {27'b0, div_m}, 32'd0);
    chk("rst_out_err", {29'b0, out_err}, 32'd0);
    chk("rst_div_dividend", div_dividend, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    run_100_7("d100_7");

    s0 = starts;
    send(32'h7FFF_FFFF, 32'd1);
    wait_resp(200);
    chk("max_m", {27'b0, div_m}, 32'd31);
    chk("max_n", {27'b0, div_n}, 32'd1);
    chk("max_starts", starts - s0, 32'd1);
    chk("max_q", out_q, 32'h7FFF_FFFF);
    chk("max_rem", out_rem, 32'd0);
    take();

    s0 = starts;
    send(32'd5, 32'd0);
    chk("div0_valid", {31'b0, out_valid}, 32'd1);
    chk("div0_q", out_q, 32'd0);
    chk("div0_rem", out_rem, 32'd5);
    chk("div0_err", {29'b0, out_err}, 32'd1);
    // hold off the response and make sure nothing moves
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_rem", out_rem, 32'd5);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    chk("div0_starts", starts - s0, 32'd0);
    take();

    send(32'h8000_0000, 32'd3);
    wait_resp(5);
    chk("range_err", {29'b0, out_err}, 32'd2);
    chk("range_q", out_q, 32'd0);
    chk("range_rem", out_rem, 32'd0);
    take();

    s0 = starts;
    send(32'd3, 32'd12);
    step(30);
    chk("triv_not_yet", {31'b0, out_valid}, 32'd0);
    step(1);
    chk("triv_valid_on_time", {31'b0, out_valid}, 32'd1);
    chk("triv_q", out_q, 32'd0);
    chk("triv_rem", out_rem, 32'd3);
    chk("triv_err", {29'b0, out_err}, 32'd0);
    chk("triv_starts", starts - s0, 32'd0);
    take();

    stub = 1'b1;
    send(32'd9, 32'd2);
    step(95);
    chk("to_not_yet", {31'b0, out_valid}, 32'd0);
    step(1);
    chk("to_valid", {31'b0, out_valid}, 32'd1);
    chk("to_err", {29'b0, out_err}, 32'd4);
    chk("to_q", out_q, 32'd0);
    chk("to_rem", out_rem, 32'd0);
    take();
    stub = 1'b0;
    step(10);

    // reset while waiting for done to rise
    send(32'd100, 32'd7);
    step(34);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    step(2);
    rst_n = 1'b1;
    step(12);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    run_100_7("after_rst");

    chk("no_double_start", dbl, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
